spi_loader_seq: RTL and testbench
=================================

# spi_loader_seq

Sequencer that turns AXI-side load commands into SPI master frames toward the ODIN core's configuration SPI slave. One command is one frame of {address, data}, shifted MSB first in SPI mode 0. It sits between the AXI_SPI_LOADER register file, which supplies the command handshake, and the SPI pins. It optionally captures MISO readback and returns it as a one-cycle response.

## Interface

Parameters:
- ADDR_W, 20, address field width in bits
- DATA_W, 20, data field width in bits; frame width FRAME_W = ADDR_W + DATA_W
- CLK_DIV, 2, ACLK cycles per SCK half-period; legal values are 1 or more
- CS_GAP, 2, ACLK cycles CS_N stays high between frames; legal values are 1 or more

Ports:
- ACLK, in, 1, the single clock
- ARESET, in, 1, reset; synchronous and active-high
- cmd_valid, in, 1, a command is presented
- cmd_ready, out, 1, the sequencer accepts the command this cycle
- cmd_addr, in, ADDR_W, frame address field
- cmd_data, in, DATA_W, frame data field
- rsp_valid, out, 1, one-cycle pulse when a frame completes
- rsp_data, out, DATA_W, MISO bits captured during the data field
- busy, out, 1, a frame is in progress (any state other than IDLE)
- SCK, out, 1, SPI clock; idles low
- MOSI, out, 1, SPI data out
- MISO, in, 1, SPI data in; already synchronous to ACLK
- CS_N, out, 1, SPI chip select, active-low

## Operation

- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch {cmd_addr, cmd_data} into shift register sr[FRAME_W-1:0] and go to SETUP.
  - SETUP: CS_N = 0, SCK = 0, MOSI = sr[FRAME_W-1]. Lasts CLK_DIV cycles, then go to SHIFT.
  - SHIFT: FRAME_W SCK periods. Each period is CLK_DIV cycles with SCK high, then CLK_DIV cycles with SCK low.
    - On the SCK low-to-high transition, sample MISO into rx[0] and shift rx left.
    - On the SCK high-to-low transition, shift sr left so MOSI presents the next bit.
    - After the FRAME_W-th low half, go to GAP.
  - GAP: CS_N = 1, SCK = 0. Lasts CS_GAP cycles, then go to IDLE.
- Bit counter is clog2(FRAME_W+1) bits wide. Divider counter is clog2(CLK_DIV) bits wide (minimum 1) and wraps at CLK_DIV-1.
- rsp_data = rx[DATA_W-1:0], i.e. the last DATA_W sampled bits. The address-phase MISO bits are discarded.
- cmd_valid while busy: ignored. cmd_ready stays 0 and the command is not consumed.
- cmd_addr and cmd_data are sampled only in the accept cycle; later changes have no effect.
- Reset mid-frame: next cycle CS_N = 1, SCK = 0, state = IDLE, partial frame dropped, no rsp_valid.

## Timing

- Reset values:
  - cmd_ready = 1
  - rsp_valid = 0
  - rsp_data = 0
  - busy = 0
  - SCK = 0
  - MOSI = 0
  - CS_N = 1
- All outputs are registered.
- Accept at cycle 0 gives:
  - CS_N low on cycles 1 .. CLK_DIV*(2*FRAME_W+1).
  - First SCK rise at cycle 1+CLK_DIV.
  - rsp_valid high for exactly one cycle, the first GAP cycle, cycle CLK_DIV*(2*FRAME_W+1)+1.
  - cmd_ready returns on cycle CLK_DIV*(2*FRAME_W+1)+CS_GAP+1.
- Defaults (CLK_DIV = 2, FRAME_W = 40, CS_GAP = 2): CS_N low cycles 1–162, rsp_valid at 163, cmd_ready at 165. Frame-to-frame period is 165 cycles.
- MOSI is stable for at least CLK_DIV cycles around every SCK rise.
- MOSI returns to 0 in GAP and IDLE.

## Configuration

- SPI_LOADER_RDBK_EN defined: rx shift register and MISO capture are built; rsp_valid and rsp_data behave as above.
- SPI_LOADER_RDBK_EN undefined:
  - rx is removed and MISO is unused.
  - rsp_data is tied to 0.
  - rsp_valid still pulses in the first GAP cycle as a frame-done indication.
  - All other timing is identical.

## Structure

- Package spi_loader_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, GAP)
  - FRAME_W default constant
  - frame typedef struct {addr, data}
- Sub-module spi_loader_clkgen: CLK_DIV divider producing one-cycle sck_rise and sck_fall strobes and the registered SCK.
  - Enabled by the FSM only in SHIFT.
  - Cleared by ARESET and on leaving SHIFT.
- The FSM, shift registers and bit counter stay in spi_loader_seq.

## Test plan

- Single write, defaults, cmd_addr = 20'hA5A5A, cmd_data = 20'h12345: MOSI sampled on the 40 SCK rises equals 40'hA5A5A12345; CS_N low cycles 1–162; cmd_ready back at cycle 165.
- Readback (RDBK_EN): slave model drives 20'hF0F0F on MISO during the data phase and 1s during the address phase -> one rsp_valid pulse at cycle 163 with rsp_data = 20'hF0F0F.
- Back-to-back: cmd_valid held high with two commands -> second accepted exactly at cycle 165; CS_N high for exactly CS_GAP = 2 cycles between frames.
- Busy-time request: new cmd_valid at cycle 50 -> not consumed until cycle 165; frame 1 MOSI is unaffected.
- Reset mid-frame: ARESET pulse at cycle 80 -> cycle 81 shows CS_N = 1, SCK = 0, cmd_ready = 1, and no rsp_valid is ever produced for that frame.
- CLK_DIV = 1, CS_GAP = 1 -> CS_N low cycles 1–81, rsp_valid at 82, cmd_ready at 83; SCK toggles every cycle in SHIFT.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI loader sequencer.
// The state encoding is also visible on the sequencer's dbg_state port.
package spi_loader_pkg;

    localparam int ADDR_W_DEF  = 20;
    localparam int DATA_W_DEF  = 20;
    localparam int FRAME_W_DEF = ADDR_W_DEF + DATA_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // One frame as it appears on the wire: address first, MSB first.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } frame_t;

    // Width of a down-counter that must hold values up to max(a, b).
    function automatic int wait_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_loader_clkgen.sv
// SCK generator for the SPI loader. While en is high, SCK toggles every
// CLK_DIV cycles, starting with a rise on the first enabled edge. The
// sck_rise / sck_fall strobes are high in the cycle whose closing edge
// moves SCK. Dropping en returns SCK low and re-arms the divider.
module spi_loader_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall,
    output logic half_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // The divider is parked at its wrap value so the first enabled edge rises.
    assign half_end = (div_cnt == DIV_MAX);
    assign sck_rise = en && half_end && !sck;
    assign sck_fall = en && half_end && sck;

    // Divider counter and registered SCK; cleared whenever not enabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= DIV_MAX;
            sck     <= 1'b0;
        end else begin
            if (half_end) begin
                div_cnt <= '0;
                sck     <= !sck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_loader_seq.sv
// SPI loader sequencer: turns one {addr, data} command into one SPI mode-0
// frame, MSB first, and pulses rsp_valid in the first CS_N-high cycle.
// Optional feature macro: SPI_LOADER_RDBK_EN builds the MISO capture path
// and returns the data-phase bits on rsp_data; without it rsp_data is 0.
// Handshake: a command transfers on a cycle where cmd_valid and cmd_ready
// are both high; cmd_ready is high only in IDLE, so commands presented
// while busy stay pending and are not consumed.
module spi_loader_seq
    import spi_loader_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 20,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS_N,
    output logic [1:0]        dbg_state
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int WAIT_W  = wait_width(CLK_DIV, CS_GAP);

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_W);
    localparam logic [WAIT_W-1:0] SETUP_LOAD = WAIT_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LOAD   = WAIT_W'(CS_GAP - 1);

    state_t              state;
    state_t              state_n;
    logic [FRAME_W-1:0]  sr;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_n;
    logic                accept;
    logic                done;
    logic                sck_en;
    logic                sck_rise;
    logic                sck_fall;
    logic                half_end;

    assign dbg_state = state;

    // SCK runs only while the FSM is (or is about to be) shifting, so the
    // first rise lines up with the SETUP -> SHIFT transition.
    assign sck_en = (state_n == SHIFT);

    spi_loader_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (ACLK),
        .rst      (ARESET),
        .en       (sck_en),
        .sck      (SCK),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .half_end (half_end)
    );

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // Next-state logic; SETUP and GAP time out on a shared down-counter.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    wait_cnt_n = SETUP_LOAD;
                    state_n    = SETUP;
                end
            end
            SETUP: begin
                if (wait_cnt == '0) begin
                    state_n = SHIFT;
                end else begin
                    wait_cnt_n = wait_cnt - 1'b1;
                end
            end
            SHIFT: begin
                // End of the low half that follows the last falling edge.
                if (half_end && !SCK && (bit_cnt == BIT_LAST)) begin
                    done       = 1'b1;
                    wait_cnt_n = GAP_LOAD;
                    state_n    = GAP;
                end
            end
            GAP: begin
                if (wait_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Transmit shift register, bit counter and registered pin/status outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sr        <= '0;
            bit_cnt   <= '0;
            MOSI      <= 1'b0;
            CS_N      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            CS_N      <= !((state_n == SETUP) || (state_n == SHIFT));
            rsp_valid <= done;
            if (accept) begin
                sr      <= {cmd_addr, cmd_data};
                bit_cnt <= '0;
                MOSI    <= cmd_addr[ADDR_W-1];
            end else if (sck_fall) begin
                sr      <= {sr[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                MOSI    <= sr[FRAME_W-2];
            end else if ((state_n == GAP) || (state_n == IDLE)) begin
                MOSI <= 1'b0;
            end
        end
    end

`ifdef SPI_LOADER_RDBK_EN
    logic [DATA_W-1:0] rx;

    // MISO capture on each SCK rise; only the last DATA_W bits survive.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rx       <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                rx <= '0;
            end else if (sck_rise) begin
                rx <= {rx[DATA_W-2:0], MISO};
            end
            if (done) begin
                rsp_data <= rx;
            end
        end
    end
`else
    logic unused_rdbk;

    assign unused_rdbk = ^{MISO, sck_rise};
    assign rsp_data    = '0;
`endif

endmodule

// File: tb/tb_spi_loader_seq.sv
// Directed bench for spi_loader_seq: a default-parameter instance and a
// CLK_DIV=1 / CS_GAP=1 instance, checked cycle by cycle against
// hand-derived frame timing.
module tb_spi_loader_seq;
    import spi_loader_pkg::*;

    localparam int F = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic        cv0, cv1;
    logic [19:0] ca0, ca1, cd0, cd1;
    logic        miso0, miso1;
    logic        cr0, rv0, busy0, sck0, mosi0, csn0;
    logic        cr1, rv1, busy1, sck1, mosi1, csn1;
    logic [19:0] rd0, rd1;
    logic [1:0]  st0, st1;

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;

    logic        o_sck, o_mosi, o_csn, o_rv, o_cr, o_busy;
    logic [19:0] o_rd;

    spi_loader_seq dut0 (
        .ACLK(clk), .ARESET(areset), .cmd_valid(cv0), .cmd_ready(cr0),
        .cmd_addr(ca0), .cmd_data(cd0), .rsp_valid(rv0), .rsp_data(rd0),
        .busy(busy0), .SCK(sck0), .MOSI(mosi0), .MISO(miso0), .CS_N(csn0),
        .dbg_state(st0)
    );

    spi_loader_seq #(.CLK_DIV(1), .CS_GAP(1)) dut1 (
        .ACLK(clk), .ARESET(areset), .cmd_valid(cv1), .cmd_ready(cr1),
        .cmd_addr(ca1), .cmd_data(cd1), .rsp_valid(rv1), .rsp_data(rd1),
        .busy(busy1), .SCK(sck1), .MOSI(mosi1), .MISO(miso1), .CS_N(csn1),
        .dbg_state(st1)
    );

    always_comb begin
        if (sel == 0) begin
            o_sck = sck0; o_mosi = mosi0; o_csn = csn0; o_rv = rv0;
            o_cr = cr0; o_busy = busy0; o_rd = rd0;
        end else begin
            o_sck = sck1; o_mosi = mosi1; o_csn = csn1; o_rv = rv1;
            o_cr = cr1; o_busy = busy1; o_rd = rd1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] rdbk(input logic [19:0] x);
`ifdef SPI_LOADER_RDBK_EN
        return x;
`else
        return 20'h0 & x;
`endif
    endfunction

    task automatic drive_cmd(input int s, input logic v, input logic [19:0] a, input logic [19:0] d);
        if (s == 0) begin
            cv0 = v; ca0 = a; cd0 = d;
        end else begin
            cv1 = v; ca1 = a; cd1 = d;
        end
    endtask

    task automatic set_miso(input int s, input logic b);
        if (s == 0) miso0 = b;
        else        miso1 = b;
    endtask

    // One-cycle command; inputs are scrambled right after the accept edge.
    task automatic accept(input int s, input logic [19:0] a, input logic [19:0] d);
        @(posedge clk);
        #1 drive_cmd(s, 1'b1, a, d);
        @(posedge clk);
        #1 drive_cmd(s, 1'b0, ~a, ~d);
    endtask

    // Called in cycle 1 after an accept; returns at the negedge of the
    // cycle in which cmd_ready is back.
    task automatic observe_frame(input int s, input int d, input int g,
                                 input logic [39:0] exp_frame, input logic [39:0] miso_frame,
                                 input int raise_at, input logic [19:0] na, input logic [19:0] nd,
                                 input logic [19:0] exp_rsp, input string name);
        int last;
        int fin;
        int rises;
        logic [39:0] cap;
        logic prev_sck;
        logic prev_mosi;
        logic exp_sck;
        last = d * (2 * F + 1);
        fin = last + g + 1;
        rises = 0;
        cap = '0;
        prev_sck = 1'b0;
        prev_mosi = 1'b0;
        set_miso(s, miso_frame[F-1]);
        for (int c = 1; c <= fin; c++) begin
            @(negedge clk);
            exp_sck = (c >= d + 1 && c <= last) ? ((((c - d - 1) / d) % 2) == 0) : 1'b0;
            chk1({name, ".sck"}, o_sck, exp_sck);
            chk1({name, ".cs_n"}, o_csn, (c > last));
            chk1({name, ".rsp_valid"}, o_rv, (c == last + 1));
            chk1({name, ".cmd_ready"}, o_cr, (c == fin));
            chk1({name, ".busy"}, o_busy, (c != fin));
            if (c == last + 1) chkv({name, ".rsp_data"}, 64'(o_rd), 64'(exp_rsp));
            if (c > last) chk1({name, ".mosi_idle"}, o_mosi, 1'b0);
            if (o_sck === 1'b1 && prev_sck === 1'b0) begin
                chk1({name, ".mosi_setup"}, o_mosi, prev_mosi);
                cap = {cap[38:0], o_mosi};
                rises++;
                if (rises < F) set_miso(s, miso_frame[F-1-rises]);
            end
            prev_sck = o_sck;
            prev_mosi = o_mosi;
            if (c == raise_at) drive_cmd(s, 1'b1, na, nd);
        end
        chkv({name, ".rises"}, 64'(rises), 64'(F));
        chkv({name, ".mosi_frame"}, 64'(cap), 64'(exp_frame));
    endtask

    initial begin
        int pulses;
        areset = 1'b1;
        cv0 = 1'b0; cv1 = 1'b0;
        ca0 = '0; ca1 = '0; cd0 = '0; cd1 = '0;
        miso0 = 1'b0; miso1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);

        // Reset values
        chk1("rst.cmd_ready", cr0, 1'b1);
        chk1("rst.rsp_valid", rv0, 1'b0);
        chkv("rst.rsp_data", 64'(rd0), 64'h0);
        chk1("rst.busy", busy0, 1'b0);
        chk1("rst.sck", sck0, 1'b0);
        chk1("rst.mosi", mosi0, 1'b0);
        chk1("rst.cs_n", csn0, 1'b1);
        chkv("rst.state", 64'(st0), 64'(IDLE));
        chk1("rst1.cmd_ready", cr1, 1'b1);
        chk1("rst1.cs_n", csn1, 1'b1);
        chkv("rst1.rsp_data", 64'(rd1), 64'h0);

        // Single write with readback pattern: 1s in address phase, F0F0F in data phase
        sel = 0;
        accept(0, 20'hA5A5A, 20'h12345);
        observe_frame(0, 2, 2, 40'hA5A5A12345, {20'hFFFFF, 20'hF0F0F}, -1,
                      20'h0, 20'h0, rdbk(20'hF0F0F), "single");

        // Back-to-back: cmd_valid held high, second command waits for cycle 165
        @(posedge clk);
        #1 drive_cmd(0, 1'b1, 20'h0F00F, 20'hC3C3C);
        @(posedge clk);
        #1 drive_cmd(0, 1'b1, 20'h3CA51, 20'h0BEEF);
        observe_frame(0, 2, 2, 40'h0F00FC3C3C, {20'h00000, 20'h5A5A5}, -1,
                      20'h0, 20'h0, rdbk(20'h5A5A5), "b2b1");
        @(posedge clk);
        #1 drive_cmd(0, 1'b0, 20'h0, 20'h0);
        observe_frame(0, 2, 2, 40'h3CA510BEEF, {20'hFFFFF, 20'h00001}, -1,
                      20'h0, 20'h0, rdbk(20'h00001), "b2b2");

        // Request raised at cycle 50 of a frame
        accept(0, 20'h13579, 20'h2468A);
        observe_frame(0, 2, 2, 40'h135792468A, {20'h55555, 20'hAAAAA}, 50,
                      20'hFEDCB, 20'hA9876, rdbk(20'hAAAAA), "busy1");
        @(posedge clk);
        #1 drive_cmd(0, 1'b0, 20'h0, 20'h0);
        observe_frame(0, 2, 2, 40'hFEDCBA9876, {20'h00000, 20'h12345}, -1,
                      20'h0, 20'h0, rdbk(20'h12345), "busy2");

        // Reset pulse at cycle 80 of a frame
        accept(0, 20'h77777, 20'h88888);
        for (int c = 1; c <= 80; c++) @(negedge clk);
        areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("mrst.cs_n", csn0, 1'b1);
        chk1("mrst.sck", sck0, 1'b0);
        chk1("mrst.cmd_ready", cr0, 1'b1);
        chk1("mrst.busy", busy0, 1'b0);
        chk1("mrst.mosi", mosi0, 1'b0);
        chkv("mrst.state", 64'(st0), 64'(IDLE));
        areset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rv0 === 1'b1) pulses++;
        end
        chkv("mrst.no_rsp", 64'(pulses), 64'h0);

        // Fastest configuration on the second instance
        sel = 1;
        accept(1, 20'h80001, 20'h7FFFE);
        observe_frame(1, 1, 1, 40'h800017FFFE, {20'h00000, 20'hC0FFE}, -1,
                      20'h0, 20'h0, rdbk(20'hC0FFE), "div1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
